// File: rtl/noc_pkg.sv
// Shared types and constants for the NoC filter multicast controller.
// The state encoding and the broadcast tag live here so every block uses the same values.
package noc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DRAIN,
    ST_DONE
  } ctrl_state_e;

  // A tag of all ones addresses every row (or column); slice it to the tag width in use.
  localparam int unsigned TAG_MAX_WIDTH = 32;
  localparam logic [TAG_MAX_WIDTH-1:0] TAG_WILDCARD = '1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; the head entry is read directly from the array.
// DEPTH must be a power of two and at least 2.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  logic do_push;
  logic do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage is deliberately left out of reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // The extra pointer bit tells a wrapped (full) buffer apart from an empty one.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/filter_multicast_controller.sv
// Accepts tagged filter-weight packets, keeps those addressed to this row/column (or broadcast),
// buffers them toward the PE and counts deliveries for one configured pass.
module filter_multicast_controller
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int ROW_TAG_WIDTH = 4,
  parameter int COL_TAG_WIDTH = 4,
  parameter int FIFO_DEPTH    = 2,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_load,
  input  logic [ROW_TAG_WIDTH-1:0] cfg_row_id,
  input  logic [COL_TAG_WIDTH-1:0] cfg_col_id,
  input  logic [CNT_WIDTH-1:0]     cfg_expected,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic [ROW_TAG_WIDTH-1:0] in_row_tag,
  input  logic [COL_TAG_WIDTH-1:0] in_col_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_WIDTH-1:0]     match_count
);

  localparam logic [CNT_WIDTH-1:0]     CNT_ONE  = 1;
  localparam logic [ROW_TAG_WIDTH-1:0] ROW_WILD = TAG_WILDCARD[ROW_TAG_WIDTH-1:0];
  localparam logic [COL_TAG_WIDTH-1:0] COL_WILD = TAG_WILDCARD[COL_TAG_WIDTH-1:0];

  ctrl_state_e              state;
  logic [ROW_TAG_WIDTH-1:0] row_id_q;
  logic [COL_TAG_WIDTH-1:0] col_id_q;
  logic [CNT_WIDTH-1:0]     expected_q;
  logic                     busy_q;
  logic                     done_q;

  logic                  is_match;
  logic                  target_reached;
  logic                  accept_ready;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] head_data;

  assign is_match       = ((in_row_tag == row_id_q) || (in_row_tag == ROW_WILD)) &&
                          ((in_col_tag == col_id_q) || (in_col_tag == COL_WILD));
  assign target_reached = (match_count == expected_q);

  // Once the target count is reached nothing more is taken, so the count can never overshoot.
  // Fullness is judged before any same-cycle pop, keeping in_ready independent of out_ready.
  assign accept_ready = (state == ST_ACTIVE) && !target_reached && (!is_match || !fifo_full);
  assign fifo_push    = in_valid && accept_ready && is_match;
  assign fifo_pop     = out_valid && out_ready;

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (in_data),
    .pop       (fifo_pop),
    .pop_data  (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Handshake and status outputs are forced low while reset is asserted, before the first edge lands.
  assign in_ready  = reset && accept_ready;
  assign out_valid = reset && !fifo_empty;
  assign out_data  = out_valid ? head_data : '0;
  assign busy      = reset && busy_q;
  assign done      = reset && done_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      row_id_q    <= '0;
      col_id_q    <= '0;
      expected_q  <= '0;
      match_count <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (cfg_load) begin
            row_id_q    <= cfg_row_id;
            col_id_q    <= cfg_col_id;
            expected_q  <= cfg_expected;
            match_count <= '0;
            busy_q      <= 1'b1;
            state       <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (fifo_push) match_count <= match_count + CNT_ONE;
          if (target_reached) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (fifo_empty) begin
            done_q <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_multicast_controller.sv
// Self-checking bench for filter_multicast_controller: packet tables per pass, a payload
// scoreboard checked at the PE side, and hand-written backpressure / zero-count / reset sequences.
module tb_filter_multicast_controller;

  localparam int DW  = 16;
  localparam int RW  = 4;
  localparam int CW  = 4;
  localparam int CNW = 8;

  typedef struct {
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [DW-1:0] data;
    logic          match;
  } pkt_vec_t;

  logic           clk = 1'b0;
  logic           reset;
  logic           cfg_load;
  logic [RW-1:0]  cfg_row_id;
  logic [CW-1:0]  cfg_col_id;
  logic [CNW-1:0] cfg_expected;
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  in_data;
  logic [RW-1:0]  in_row_tag;
  logic [CW-1:0]  in_col_tag;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_data;
  logic           busy;
  logic           done;
  logic [CNW-1:0] match_count;

  int            vectors     = 0;
  int            miscompares = 0;
  int            done_seen   = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  filter_multicast_controller #(
    .DATA_WIDTH    (DW),
    .ROW_TAG_WIDTH (RW),
    .COL_TAG_WIDTH (CW),
    .FIFO_DEPTH    (2),
    .CNT_WIDTH     (CNW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_load     (cfg_load),
    .cfg_row_id   (cfg_row_id),
    .cfg_col_id   (cfg_col_id),
    .cfg_expected (cfg_expected),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_row_tag   (in_row_tag),
    .in_col_tag   (in_col_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .busy         (busy),
    .done         (done),
    .match_count  (match_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // PE side: every delivered payload must be the oldest one still owed.
  always @(negedge clk) begin
    logic [DW-1:0] want;
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_output: got 0x%0h, want no payload at %0t", out_data, $time);
      end else begin
        want = exp_q.pop_front();
        check("out_data_order", {16'h0, out_data}, {16'h0, want});
      end
    end
    if (done) done_seen++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pass(input logic [RW-1:0] r, input logic [CW-1:0] c, input logic [CNW-1:0] e);
    cfg_load     = 1'b1;
    cfg_row_id   = r;
    cfg_col_id   = c;
    cfg_expected = e;
    tick();
    cfg_load  = 1'b0;
    done_seen = 0;
  endtask

  // Offers one packet; with a free buffer it must be taken in its first cycle.
  task automatic send_packet(input string name, input pkt_vec_t v);
    bit taken = 0;
    in_valid   = 1'b1;
    in_row_tag = v.row;
    in_col_tag = v.col;
    in_data    = v.data;
    @(negedge clk);
    check({name, "_in_ready"}, {31'h0, in_ready}, 32'h1);
    for (int i = 0; i < 20 && !taken; i++) begin
      if (i > 0) @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        if (v.match) exp_q.push_back(v.data);
        taken = 1;
        #1;
      end else begin
        tick();
      end
    end
    if (!taken) check({name, "_accept_timeout"}, 32'h0, 32'h1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit idle = 0;
    for (int i = 0; i < 100 && !idle; i++) begin
      @(negedge clk);
      if (!busy) idle = 1;
    end
    if (!idle) check({name, "_idle_timeout"}, 32'h0, 32'h1);
    tick();
  endtask

  task automatic finish_pass(input string name, input logic [CNW-1:0] exp_count);
    wait_idle(name);
    check({name, "_done_pulses"}, done_seen, 1);
    check({name, "_match_count"}, {24'h0, match_count}, {24'h0, exp_count});
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  pkt_vec_t uni_tbl[3];
  pkt_vec_t flt_tbl[8];
  logic [CNW-1:0] n_match;
  logic exp_busy[4];
  logic exp_done[4];

  initial begin
    uni_tbl[0] = '{row: 4'h2, col: 4'h3, data: 16'h0011, match: 1'b1};
    uni_tbl[1] = '{row: 4'h2, col: 4'h3, data: 16'h0022, match: 1'b1};
    uni_tbl[2] = '{row: 4'h2, col: 4'h3, data: 16'h0033, match: 1'b1};

    flt_tbl[0] = '{row: 4'h1, col: 4'h3, data: 16'h0001, match: 1'b0};
    flt_tbl[1] = '{row: 4'h2, col: 4'h0, data: 16'h0002, match: 1'b0};
    flt_tbl[2] = '{row: 4'h2, col: 4'h3, data: 16'h00AA, match: 1'b1};
    flt_tbl[3] = '{row: 4'hF, col: 4'h3, data: 16'h00B1, match: 1'b1};
    flt_tbl[4] = '{row: 4'h2, col: 4'hF, data: 16'h00B2, match: 1'b1};
    flt_tbl[5] = '{row: 4'h3, col: 4'hF, data: 16'h0003, match: 1'b0};
    flt_tbl[6] = '{row: 4'hE, col: 4'h3, data: 16'h0004, match: 1'b0};
    flt_tbl[7] = '{row: 4'hF, col: 4'hF, data: 16'h00B3, match: 1'b1};

    exp_busy = '{1'b1, 1'b1, 1'b1, 1'b0};
    exp_done = '{1'b0, 1'b0, 1'b1, 1'b0};

    reset        = 1'b0;
    cfg_load     = 1'b0;
    cfg_row_id   = '0;
    cfg_col_id   = '0;
    cfg_expected = '0;
    in_valid     = 1'b0;
    in_data      = '0;
    in_row_tag   = '0;
    in_col_tag   = '0;
    out_ready    = 1'b1;

    // Reset held, then the first cycle after release.
    tick();
    tick();
    @(negedge clk);
    check("rst_held_outputs", {27'h0, in_ready, out_valid, busy, done, |out_data}, 32'h0);
    check("rst_held_count", {24'h0, match_count}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_release_outputs", {27'h0, in_ready, out_valid, busy, done, |out_data}, 32'h0);
    tick();

    // Unicast pass.
    start_pass(4'h2, 4'h3, 8'd3);
    for (int i = 0; i < 3; i++) send_packet($sformatf("uni%0d", i), uni_tbl[i]);
    finish_pass("uni", 8'd3);

    // Filtering and wildcard pass: non-matching tags are consumed and dropped.
    n_match = '0;
    for (int i = 0; i < 8; i++) if (flt_tbl[i].match) n_match = n_match + 8'd1;
    start_pass(4'h2, 4'h3, n_match);
    for (int i = 0; i < 8; i++) send_packet($sformatf("flt%0d", i), flt_tbl[i]);
    finish_pass("flt", n_match);

    // Backpressure: two fill the buffer, the third waits with the head held.
    out_ready = 1'b0;
    start_pass(4'h2, 4'h3, 8'd3);
    send_packet("bp0", '{row: 4'h2, col: 4'h3, data: 16'h0051, match: 1'b1});
    send_packet("bp1", '{row: 4'h2, col: 4'h3, data: 16'h0052, match: 1'b1});
    in_valid   = 1'b1;
    in_row_tag = 4'h2;
    in_col_tag = 4'h3;
    in_data    = 16'h0053;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_full_in_ready", {31'h0, in_ready}, 32'h0);
      check("bp_head_hold", {15'h0, out_valid, out_data}, {15'h0, 1'b1, 16'h0051});
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_pop_no_free", {31'h0, in_ready}, 32'h0);
    begin
      bit taken = 0;
      for (int i = 0; i < 20 && !taken; i++) begin
        @(negedge clk);
        if (in_ready) begin
          @(posedge clk);
          exp_q.push_back(16'h0053);
          taken = 1;
          #1;
        end
      end
      if (!taken) check("bp_third_accept_timeout", 32'h0, 32'h1);
    end
    in_valid = 1'b0;
    finish_pass("bp", 8'd3);

    // Zero expected count: ACTIVE, DRAIN, DONE, IDLE with a matching packet left untaken.
    start_pass(4'h2, 4'h3, 8'd0);
    in_valid   = 1'b1;
    in_row_tag = 4'h2;
    in_col_tag = 4'h3;
    in_data    = 16'h0099;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("zero_c%0d_busy_done", i), {30'h0, busy, done}, {30'h0, exp_busy[i], exp_done[i]});
      check($sformatf("zero_c%0d_in_ready", i), {30'h0, in_ready, out_valid}, 32'h0);
      tick();
    end
    in_valid = 1'b0;
    check("zero_done_pulses", done_seen, 1);
    check("zero_match_count", {24'h0, match_count}, 32'h0);

    // Reset mid-pass with one payload buffered.
    out_ready = 1'b0;
    start_pass(4'h2, 4'h3, 8'd2);
    send_packet("rmid0", '{row: 4'h2, col: 4'h3, data: 16'h0077, match: 1'b1});
    @(negedge clk);
    check("rmid_buffered", {15'h0, out_valid, out_data}, {15'h0, 1'b1, 16'h0077});
    reset = 1'b0;
    #1;
    check("rmid_held_outputs", {28'h0, in_ready, out_valid, busy, done}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    out_ready = 1'b1;
    @(negedge clk);
    check("rmid_after_outputs", {27'h0, in_ready, out_valid, busy, done, |out_data}, 32'h0);
    check("rmid_count_cleared", {24'h0, match_count}, 32'h0);
    for (int i = 0; i < 5; i++) tick();
    check("rmid_no_done", done_seen, 0);
    check("rmid_idle", {31'h0, busy}, 32'h0);

    // Recovery pass after the mid-pass reset.
    start_pass(4'h2, 4'h3, 8'd1);
    send_packet("rec0", '{row: 4'h2, col: 4'h3, data: 16'h005A, match: 1'b1});
    finish_pass("rec", 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/filter_multicast_controller.md
FILTER_MULTICAST_CONTROLLER -- requirements
Module: filter_multicast_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: filter weight payload width.
REQ-002 SHALL have parameter ROW_TAG_WIDTH, default 4: row tag / row ID width.
REQ-003 SHALL have parameter COL_TAG_WIDTH, default 4: column tag / column ID width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 2: output buffer entries, power of two, at least 2.
REQ-005 SHALL have parameter CNT_WIDTH, default 8: delivered-packet counter width.
REQ-006 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-007 SHALL have port reset, input, 1: reset is synchronous and active-low.
REQ-008 SHALL have port cfg_load, input, 1: latches the configuration and starts a pass; honoured only in IDLE.
REQ-009 SHALL have port cfg_row_id, input, ROW_TAG_WIDTH: this controller's row ID.
REQ-010 SHALL have port cfg_col_id, input, COL_TAG_WIDTH: this controller's column ID.
REQ-011 SHALL have port cfg_expected, input, CNT_WIDTH: number of matching packets to deliver this pass.
REQ-012 SHALL have port in_valid, input, 1: a tagged packet is offered.
REQ-013 SHALL have port in_ready, output, 1: the packet is consumed when in_valid and in_ready are both high.
REQ-014 SHALL have port in_data, input, DATA_WIDTH: packet payload.
REQ-015 SHALL have port in_row_tag, input, ROW_TAG_WIDTH: destination row tag from the filter tag generator.
REQ-016 SHALL have port in_col_tag, input, COL_TAG_WIDTH: destination column tag.
REQ-017 SHALL have port out_valid, input/output as follows: output, 1: the buffered payload is valid toward the PE.
REQ-018 SHALL have port out_ready, input, 1: the PE accepts the payload.
REQ-019 SHALL have port out_data, output, DATA_WIDTH: payload at the buffer head.
REQ-020 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-021 SHALL have port done, output, 1: one-cycle pulse when a pass completes.
REQ-022 SHALL have port match_count, output, CNT_WIDTH: number of matching packets accepted in the current pass.

Function
REQ-023 SHALL implement the states IDLE, ACTIVE, DRAIN and DONE.
REQ-024 SHALL latch cfg_row_id, cfg_col_id and cfg_expected, clear match_count and move to ACTIVE when cfg_load is high in IDLE; cfg_load in any other state SHALL be ignored.
REQ-025 SHALL treat a packet as matching when (in_row_tag == row ID or in_row_tag is all-ones) and (in_col_tag == column ID or in_col_tag is all-ones).
REQ-026 SHALL, in ACTIVE, drive in_ready = 1 for a non-matching packet (consume and drop) and in_ready = (buffer occupancy < FIFO_DEPTH) for a matching packet.
REQ-027 SHALL drive in_ready = 0 in IDLE, DRAIN and DONE.
REQ-028 SHALL push an accepted matching packet into the buffer and increment match_count in the same cycle.
REQ-029 SHALL present a pushed payload on out_valid/out_data no earlier than the next cycle, with no combinational path from in_* to out_*.
REQ-030 SHALL keep in_ready for a matching packet independent of out_ready; a same-cycle pop SHALL NOT free space for a push in that cycle.
REQ-031 SHALL allow a push and a pop in the same cycle, with occupancy unchanged.
REQ-032 SHALL pop the buffer on out_valid && out_ready and deliver payloads in strict arrival order.
REQ-033 SHALL hold out_data stable while out_valid is high and out_ready is low.
REQ-034 SHALL move from ACTIVE to DRAIN in the cycle after match_count reaches the latched cfg_expected.
REQ-035 SHALL move from ACTIVE to DRAIN in the first ACTIVE cycle when cfg_expected = 0, accepting no packets.
REQ-036 SHALL move from DRAIN to DONE when the buffer is empty.
REQ-037 SHALL pulse done for one cycle in DONE and return to IDLE on the next cycle.
REQ-038 SHALL hold match_count until the next cfg_load.

Reset
REQ-039 SHALL, on reset low at a rising edge, set the state to IDLE, empty the buffer and clear match_count and the latched configuration.
REQ-040 SHALL drive in_ready = 0, out_valid = 0, out_data = 0, busy = 0 and done = 0 while reset is held and in the first cycle after release.
REQ-041 SHALL discard buffered data on reset mid-pass, with no done pulse.

Structure
REQ-042 SHALL place the state enum typedef and the wildcard all-ones tag constant in the shared package noc_pkg.
REQ-043 SHALL implement the buffer as one sub-module, sync_fifo (parameters width and depth; push/pop/full/empty), instantiated once.

Verification
REQ-044 SHALL verify unicast: IDs (2,3), expected=3, packets tagged (2,3) with data 0x11, 0x22, 0x33, out_ready=1 -> 0x11, 0x22, 0x33 out in order, match_count=3, done pulses once.
REQ-045 SHALL verify filtering: IDs (2,3), expected=1, packets tagged (1,3), (2,0), (2,3) with data 0xAA -> the first two are consumed with in_ready=1 and dropped, only 0xAA is delivered.
REQ-046 SHALL verify wildcard: IDs (2,3), expected=2, packets tagged (F,3) and (2,F) -> both are delivered.
REQ-047 SHALL verify backpressure: out_ready=0 with 3 matching packets offered -> in_ready drops after 2 are accepted, out_data holds the first payload; raising out_ready drains all 3 in order.
REQ-048 SHALL verify expected=0: cfg_load -> sequence ACTIVE, DRAIN, DONE, IDLE with no packet accepted and a single done pulse.
REQ-049 SHALL verify reset mid-pass: 1 payload buffered, reset low for one cycle -> out_valid=0, busy=0, no done pulse, IDLE.
